// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry FIFO of {PC, instruction} pairs with flush.
// Define FETCH_QUEUE_BYPASS_EN to give zero-cycle latency through an empty queue.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             enq_valid_i,
    input  logic [31:0]      enq_pc_i,
    input  logic [31:0]      enq_instr_i,
    output logic             enq_ready_o,
    output logic             deq_valid_o,
    output logic [31:0]      deq_pc_o,
    output logic [31:0]      deq_instr_o,
    input  logic             deq_ready_i,
    output logic [PTR_W:0]   count_o
);

    localparam int unsigned CntW = PTR_W + 1;
    localparam logic [31:0] NopInstr = 32'h0000_0013;
    localparam logic [PTR_W:0] FullCount = CntW'(DEPTH);
    localparam logic [PTR_W:0] CountOne = CntW'(1);
    localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic empty, full, head_valid;
    logic enq_fire, deq_fire, push, pop;

    assign empty       = (count_q == '0);
    assign full        = (count_q == FullCount);
    assign head_valid  = !empty && !flush_i;
    assign enq_ready_o = !full && !flush_i;
    assign count_o     = count_q;

    always_comb begin
        deq_valid_o = 1'b0;
        deq_pc_o    = '0;
        deq_instr_o = NopInstr;
        if (head_valid) begin
            deq_valid_o = 1'b1;
            deq_pc_o    = pc_mem_q[rd_ptr_q];
            deq_instr_o = instr_mem_q[rd_ptr_q];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (empty && !flush_i && enq_valid_i) begin
            deq_valid_o = 1'b1;
            deq_pc_o    = enq_pc_i;
            deq_instr_o = enq_instr_i;
        end
`endif
    end

    assign enq_fire = enq_valid_i && enq_ready_o;
    assign deq_fire = deq_valid_o && deq_ready_i;
    // A dequeue from an empty queue can only be a bypassed instruction; storage is untouched.
    assign pop      = deq_fire && !empty;
`ifdef FETCH_QUEUE_BYPASS_EN
    assign push     = enq_fire && !(empty && deq_ready_i);
`else
    assign push     = enq_fire;
`endif

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= enq_pc_i;
            instr_mem_q[wr_ptr_q] <= enq_instr_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, flush, ev, dr;
    logic [31:0]       epc, eins;
    logic              er, dv;
    logic [31:0]       dpc, dins;
    logic [PTR_W:0]    cnt;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .enq_valid_i(ev),
        .enq_pc_i   (epc),
        .enq_instr_i(eins),
        .enq_ready_o(er),
        .deq_valid_o(dv),
        .deq_pc_o   (dpc),
        .deq_instr_o(dins),
        .deq_ready_i(dr),
        .count_o    (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [31:0] pc;
        logic        dr;
        logic        er;
        logic        dv;
        logic [31:0] xpc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mkv(input logic v, input logic [31:0] pc, input logic d,
                                 input logic xer, input logic xdv, input logic [31:0] xpc,
                                 input logic [2:0] xcnt);
        vec_t r;
        r.ev = v; r.pc = pc; r.dr = d; r.er = xer; r.dv = xdv; r.xpc = xpc; r.cnt = xcnt;
        return r;
    endfunction

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after an edge, then wait to the falling edge for sampling.
    task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] pc,
                         input logic d);
        rst = r; flush = f; ev = v; epc = pc; eins = ins_of(pc); dr = d;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] mq[$];

    initial begin
        // Scenario: three enqueues then drain in order.
        vt[0]  = mkv(1, 32'h00, 0, 1, BYP, 32'h00, 0);
        vt[1]  = mkv(1, 32'h04, 0, 1, 1, 32'h00, 1);
        vt[2]  = mkv(1, 32'h08, 0, 1, 1, 32'h00, 2);
        vt[3]  = mkv(0, 32'h00, 0, 1, 1, 32'h00, 3);
        vt[4]  = mkv(0, 32'h00, 1, 1, 1, 32'h00, 3);
        vt[5]  = mkv(0, 32'h00, 1, 1, 1, 32'h04, 2);
        vt[6]  = mkv(0, 32'h00, 1, 1, 1, 32'h08, 1);
        vt[7]  = mkv(0, 32'h00, 1, 1, 0, 32'h00, 0);
        // Scenario: fill to DEPTH, hold a fifth offer, release by one dequeue.
        vt[8]  = mkv(1, 32'h10, 0, 1, BYP, BYP ? 32'h10 : 32'h0, 0);
        vt[9]  = mkv(1, 32'h14, 0, 1, 1, 32'h10, 1);
        vt[10] = mkv(1, 32'h18, 0, 1, 1, 32'h10, 2);
        vt[11] = mkv(1, 32'h1C, 0, 1, 1, 32'h10, 3);
        vt[12] = mkv(1, 32'h20, 0, 0, 1, 32'h10, 4);
        vt[13] = mkv(1, 32'h20, 1, 0, 1, 32'h10, 4);
        vt[14] = mkv(1, 32'h20, 0, 1, 1, 32'h14, 3);
        vt[15] = mkv(0, 32'h00, 1, 0, 1, 32'h14, 4);
        vt[16] = mkv(0, 32'h00, 1, 1, 1, 32'h18, 3);
        vt[17] = mkv(0, 32'h00, 1, 1, 1, 32'h1C, 2);
        vt[18] = mkv(0, 32'h00, 1, 1, 1, 32'h20, 1);
        vt[19] = mkv(0, 32'h00, 0, 1, 0, 32'h00, 0);

        drive(1, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 32'h44, 1); tick();
        drive(0, 0, 0, 0, 0);
        chk("reset enq_ready", er, 1);
        chk("reset deq_valid", dv, 0);
        chk("reset deq_pc", dpc, 0);
        chk("reset deq_instr", dins, NOP);
        chk("reset count", cnt, 0);
        tick();

        for (int i = 0; i < 20; i++) begin
            drive(0, 0, vt[i].ev, vt[i].pc, vt[i].dr);
            chk($sformatf("vec%0d enq_ready", i), er, vt[i].er);
            chk($sformatf("vec%0d deq_valid", i), dv, vt[i].dv);
            chk($sformatf("vec%0d deq_pc", i), dpc, vt[i].xpc);
            chk($sformatf("vec%0d deq_instr", i), dins, vt[i].dv ? ins_of(vt[i].xpc) : NOP);
            chk($sformatf("vec%0d count", i), cnt, 32'(vt[i].cnt));
            tick();
        end

        // Steady enqueue+dequeue at occupancy 2 across pointer wrap.
        drive(0, 0, 1, 32'h100, 0); tick();
        drive(0, 0, 1, 32'h104, 0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 32'h108 + 32'(4 * i), 1);
            chk($sformatf("stream%0d count", i), cnt, 2);
            chk($sformatf("stream%0d deq_pc", i), dpc, 32'h100 + 32'(4 * i));
            tick();
        end

        // Flush with offers on both sides: nothing fires, queue empties.
        drive(0, 0, 1, 32'h300, 0); tick();
        drive(0, 1, 1, 32'h304, 1);
        chk("flush count before", cnt, 3);
        chk("flush deq_valid", dv, 0);
        chk("flush enq_ready", er, 0);
        chk("flush deq_instr", dins, NOP);
        tick();
        drive(0, 0, 1, 32'h200, 0);
        chk("post-flush count", cnt, 0);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("post-flush deq_valid", dv, 1);
        chk("post-flush deq_pc", dpc, 32'h200);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("post-flush empty", dv, 0);
        tick();

        // Reset while occupied, with an enqueue offered.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 32'h400 + 32'(4 * i), 0); tick();
        end
        drive(1, 0, 1, 32'h40C, 0); tick();
        drive(0, 0, 0, 0, 1);
        chk("mid reset count", cnt, 0);
        chk("mid reset deq_valid", dv, 0);
        chk("mid reset deq_pc", dpc, 0);
        tick();

        // Latency through an empty queue.
        drive(0, 0, 1, 32'h40, 1);
        chk("latency deq_valid", dv, BYP);
        chk("latency deq_pc", dpc, BYP ? 32'h40 : 32'h0);
        chk("latency count", cnt, 0);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("latency next deq_valid", dv, !BYP);
        chk("latency next deq_pc", dpc, BYP ? 32'h0 : 32'h40);
        chk("latency next count", cnt, BYP ? 0 : 1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("latency drained", cnt, 0);
        tick();

        // Randomized run against a queue model.
        mq.delete();
        for (int c = 0; c < 2000; c++) begin
            logic r, f, v, d, x_er, x_dv;
            logic [31:0] pc, x_pc, x_ins;
            int sz;
            r  = ($urandom_range(0, 63) == 0);
            f  = ($urandom_range(0, 31) == 0);
            v  = ($urandom_range(0, 9) < 7);
            d  = ($urandom_range(0, 9) < 5);
            pc = $urandom;
            drive(r, f, v, pc, d);
            sz   = mq.size();
            x_er = (sz != DEPTH) && !f;
            x_dv = f ? 1'b0 : (sz != 0) ? 1'b1 : (BYP && v);
            x_pc = !x_dv ? 32'h0 : (sz != 0) ? mq[0][63:32] : pc;
            x_ins = !x_dv ? NOP : (sz != 0) ? mq[0][31:0] : ins_of(pc);
            chk("rand enq_ready", er, x_er);
            chk("rand deq_valid", dv, x_dv);
            chk("rand deq_pc", dpc, x_pc);
            chk("rand deq_instr", dins, x_ins);
            chk("rand count", cnt, sz);
            if (r || f) begin
                mq.delete();
            end else if (!(x_dv && d && sz == 0)) begin
                if (x_dv && d) void'(mq.pop_front());
                if (v && x_er) mq.push_back({pc, ins_of(pc)});
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
